// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX-flush bubbles and perf counters.
// Latency: an instruction loaded on an edge is visible on ex_* one cycle later.
// Backpressure: combinational stall to IF/ID on load-use; a bubble replaces the held instruction.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   id_valid, id_ctrl, ...   decoded ID-slot instruction (ctrl order: {Branch,MemRead,MemtoReg,
//                            ALUOp[1:0],MemWrite,ALUSrc,RegWrite,Jump,Jalr})
//   ex_flush                 taken branch/jump resolved in EX; kills the ID instruction
//   stall                    hold PC and IF/ID this cycle
//   ex_*                     registered copies of the id_* fields, zero for a bubble
//   stall_cnt, flush_cnt     saturating counts of cycles with stall / ex_flush asserted
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [9:0]       id_ctrl,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             ex_flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [9:0]       ex_ctrl,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MEMREAD_BIT = 8;

    logic rd_match;
    logic load;

    // Both sources are compared regardless of opcode; a false stall only costs one cycle.
    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign rd_match = (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // A flush kills the ID instruction anyway, so stalling it would be pointless.
    assign stall = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & ~ex_flush & rd_match;

    assign load = id_valid & ~ex_flush & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
        end else if (load) begin
            ex_valid    <= 1'b1;
            ex_ctrl     <= id_ctrl;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7b5 <= id_funct7b5;
        end else begin
            // Bubble: everything zeroed so no RegWrite/MemWrite leaks downstream.
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
        end
    end

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (ex_flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed vectors, expected observations queued by the driver,
// popped and compared by a negedge monitor. Counter width is 4 to reach saturation quickly.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [9:0] LW  = 10'b0110001100;
    localparam logic [9:0] ADD = 10'b0001000100;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [9:0]       id_ctrl;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [2:0]       id_funct3;
    logic             id_funct7b5;
    logic             ex_flush;
    logic             stall;
    logic             ex_valid;
    logic [9:0]       ex_ctrl;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .ex_flush(ex_flush),
        .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // What the monitor should see at the negedge of the cycle a vector is applied.
    typedef struct {
        logic       stall;
        logic       vld;
        logic [9:0] ctrl;
        int         tag;
        int         rs1d;
        logic [4:0] rs1, rs2, rd;
        int         scnt, fcnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ex_of(input logic st, input logic v, input logic [9:0] c,
                                   input int tag, input int rs1d, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [4:0] rd,
                                   input int sc, input int fc);
        exp_t e;
        e.stall = st; e.vld = v; e.ctrl = c; e.tag = tag; e.rs1d = rs1d;
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.scnt = sc; e.fcnt = fc;
        return e;
    endfunction

    function automatic exp_t bub(input logic st, input int sc, input int fc);
        return ex_of(st, 1'b0, 10'd0, 0, 0, 5'd0, 5'd0, 5'd0, sc, fc);
    endfunction

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    // Secondary fields are derived from the tag so every registered copy gets checked.
    task automatic step(input logic v, input logic [9:0] c, input int tag, input int rs1d,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic fl, input exp_t e);
        logic [31:0] t;
        @(posedge clk);
        #1;
        t           = tag;
        id_valid    = v;
        id_ctrl     = c;
        id_pc       = t * 4;
        id_rs1_data = rs1d;
        id_rs2_data = t * 3;
        id_imm      = t * 5;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        id_funct3   = t[2:0];
        id_funct7b5 = t[3];
        ex_flush    = fl;
        sb.push_back(e);
    endtask

    task automatic idle(input exp_t e);
        step(1'b0, 10'd0, 0, 0, 5'd0, 5'd0, 5'd0, 1'b0, e);
    endtask

    task automatic chk_all_zero(input string tagname);
        chk({tagname, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tagname, " ex_ctrl"}, {22'd0, ex_ctrl}, 32'd0);
        chk({tagname, " ex_pc"}, ex_pc, 32'd0);
        chk({tagname, " ex_rs1_data"}, ex_rs1_data, 32'd0);
        chk({tagname, " ex_rd"}, {27'd0, ex_rd}, 32'd0);
        chk({tagname, " stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
        chk({tagname, " flush_cnt"}, {28'd0, flush_cnt}, 32'd0);
    endtask

    // Monitor: independent of the driver, checks whenever an expectation is pending.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] t;
            e = sb.pop_front();
            t = e.tag;
            chk("stall", {31'd0, stall}, {31'd0, e.stall});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.vld});
            chk("ex_ctrl", {22'd0, ex_ctrl}, {22'd0, e.ctrl});
            chk("ex_pc", ex_pc, t * 4);
            chk("ex_rs1_data", ex_rs1_data, e.rs1d);
            chk("ex_rs2_data", ex_rs2_data, t * 3);
            chk("ex_imm", ex_imm, t * 5);
            chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
            chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
            chk("ex_funct3", {29'd0, ex_funct3}, {29'd0, t[2:0]});
            chk("ex_funct7b5", {31'd0, ex_funct7b5}, {31'd0, t[3]});
            chk("stall_cnt", {28'd0, stall_cnt}, e.scnt);
            chk("flush_cnt", {28'd0, flush_cnt}, e.fcnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_ctrl = '0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = '0;
        id_funct7b5 = 1'b0; ex_flush = 1'b0;
        #12;
        chk_all_zero("reset");
        reset = 1'b0;

        // R-type load and a load-use pair via rs1
        step(1, ADD, 1, 5, 1, 2, 3, 0, bub(0, 0, 0));
        step(1, LW, 2, 7, 1, 0, 5, 0, ex_of(0, 1, ADD, 1, 5, 1, 2, 3, 0, 0));
        step(1, ADD, 3, 9, 5, 7, 6, 0, ex_of(1, 1, LW, 2, 7, 1, 0, 5, 0, 0));
        step(1, ADD, 3, 9, 5, 7, 6, 0, bub(0, 1, 0));
        idle(ex_of(0, 1, ADD, 3, 9, 5, 7, 6, 1, 0));
        // Load-use via rs2
        step(1, LW, 4, 11, 2, 0, 8, 0, bub(0, 1, 0));
        step(1, ADD, 5, 13, 1, 8, 9, 0, ex_of(1, 1, LW, 4, 11, 2, 0, 8, 1, 0));
        step(1, ADD, 5, 13, 1, 8, 9, 0, bub(0, 2, 0));
        // Load to x0 never stalls
        step(1, LW, 6, 15, 3, 0, 0, 0, ex_of(0, 1, ADD, 5, 13, 1, 8, 9, 2, 0));
        step(1, ADD, 7, 17, 0, 0, 10, 0, ex_of(0, 1, LW, 6, 15, 3, 0, 0, 2, 0));
        // Flush overrides a load-use hazard
        step(1, LW, 8, 19, 1, 2, 5, 0, ex_of(0, 1, ADD, 7, 17, 0, 0, 10, 2, 0));
        step(1, ADD, 9, 21, 5, 5, 4, 1, ex_of(0, 1, LW, 8, 19, 1, 2, 5, 2, 0));
        idle(bub(0, 2, 1));
        // Flush of a plain valid instruction
        step(1, ADD, 10, 23, 1, 2, 3, 1, bub(0, 2, 1));
        idle(bub(0, 2, 2));
        // Matching sources with id_valid=0: no stall, bubble
        step(1, LW, 11, 25, 0, 0, 12, 0, bub(0, 2, 2));
        step(0, ADD, 12, 0, 12, 0, 1, 0, ex_of(0, 1, LW, 11, 25, 0, 0, 12, 2, 2));
        idle(bub(0, 2, 2));
        step(1, ADD, 13, 27, 1, 2, 3, 0, bub(0, 2, 2));

        // Asynchronous reset between edges with a valid instruction in EX
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        #1;
        chk("pre-reset ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("pre-reset ex_rd", {27'd0, ex_rd}, 32'd3);
        reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        reset = 1'b0;

        step(1, ADD, 14, 29, 1, 2, 3, 0, bub(0, 0, 0));
        idle(ex_of(0, 1, ADD, 14, 29, 1, 2, 3, 0, 0));

        // 20 load-use pairs: stall_cnt saturates at 15
        for (int i = 0; i < 20; i++) begin
            int lt;
            int ut;
            lt = 20 + 2 * i;
            ut = lt + 1;
            if (i == 0)
                step(1, LW, lt, lt + 1, 1, 2, 5, 0, bub(0, 0, 0));
            else
                step(1, LW, lt, lt + 1, 1, 2, 5, 0,
                     ex_of(0, 1, ADD, lt - 1, lt, 5, 6, 7, sat(i), 0));
            step(1, ADD, ut, ut + 1, 5, 6, 7, 0, ex_of(1, 1, LW, lt, lt + 1, 1, 2, 5, sat(i), 0));
            step(1, ADD, ut, ut + 1, 5, 6, 7, 0, bub(0, sat(i + 1), 0));
        end
        idle(ex_of(0, 1, ADD, 59, 60, 5, 6, 7, 15, 0));
        idle(bub(0, 15, 0));

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard drain: %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
